// File: rtl/combo_autodialer.sv
// Plays a stored 4-digit hex combination into the lock buttons, stepping the
// shorter way round the 16-value dial for each digit before confirming it.
module combo_autodialer #(
  parameter int PRESS_CYCLES = 2,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] combo,
  output logic        btnL,
  output logic        btnR,
  output logic        btnC,
  output logic        busy,
  output logic        done,
  output logic [1:0]  digitIdx,
  output logic [3:0]  dialVal
);

  typedef enum logic [2:0] {
    IDLE, LOAD, STEP_HI, STEP_LO, CONF_HI, CONF_LO, FIN
  } state_t;

  localparam logic [7:0] PRESS_LAST = 8'(PRESS_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  state_t      state;
  logic [15:0] combo_q;
  logic [3:0]  remaining;
  logic        dir_r;
  logic [7:0]  phase;
  logic [3:0]  digit;
  logic [3:0]  delta;
  logic [3:0]  remaining_dec;

  function automatic logic [3:0] dial_step(input logic [3:0] v, input logic right);
    return right ? v + 4'd1 : v - 4'd1;
  endfunction

  always_comb begin
    digit = combo_q[15:12];
    case (digitIdx)
      2'd0: digit = combo_q[15:12];
      2'd1: digit = combo_q[11:8];
      2'd2: digit = combo_q[7:4];
      2'd3: digit = combo_q[3:0];
      default: digit = combo_q[15:12];
    endcase
  end

  assign delta         = digit - dialVal;
  assign remaining_dec = remaining - 4'd1;

  // Combination is captured once per run; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) combo_q <= combo;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      btnL      <= 1'b0;
      btnR      <= 1'b0;
      btnC      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      digitIdx  <= 2'd0;
      dialVal   <= 4'd0;
      remaining <= 4'd0;
      dir_r     <= 1'b0;
      phase     <= 8'd0;
    end else begin
      done <= 1'b0;
      if (abort && busy && state != FIN) begin
        btnL  <= 1'b0;
        btnR  <= 1'b0;
        btnC  <= 1'b0;
        phase <= 8'd0;
        state <= FIN;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              digitIdx <= 2'd0;
              busy     <= 1'b1;
              state    <= LOAD;
            end
          end
          LOAD: begin
            phase <= 8'd0;
            if (delta == 4'd0) begin
              remaining <= 4'd0;
              btnC      <= 1'b1;
              state     <= CONF_HI;
            end else begin
              // A distance of exactly 8 is equal either way; go right.
              dir_r     <= (delta <= 4'd8);
              remaining <= (delta <= 4'd8) ? delta : 4'd0 - delta;
              btnR      <= (delta <= 4'd8);
              btnL      <= (delta > 4'd8);
              dialVal   <= dial_step(dialVal, delta <= 4'd8);
              state     <= STEP_HI;
            end
          end
          STEP_HI: begin
            if (phase == PRESS_LAST) begin
              btnL  <= 1'b0;
              btnR  <= 1'b0;
              phase <= 8'd0;
              state <= STEP_LO;
            end else begin
              phase <= phase + 8'd1;
            end
          end
          STEP_LO: begin
            if (phase == GAP_LAST) begin
              phase     <= 8'd0;
              remaining <= remaining_dec;
              if (remaining_dec != 4'd0) begin
                btnR    <= dir_r;
                btnL    <= ~dir_r;
                dialVal <= dial_step(dialVal, dir_r);
                state   <= STEP_HI;
              end else begin
                btnC  <= 1'b1;
                state <= CONF_HI;
              end
            end else begin
              phase <= phase + 8'd1;
            end
          end
          CONF_HI: begin
            if (phase == PRESS_LAST) begin
              btnC  <= 1'b0;
              phase <= 8'd0;
              state <= CONF_LO;
            end else begin
              phase <= phase + 8'd1;
            end
          end
          CONF_LO: begin
            if (phase == GAP_LAST) begin
              phase <= 8'd0;
              if (digitIdx == 2'd3) begin
                state <= FIN;
              end else begin
                digitIdx <= digitIdx + 2'd1;
                state    <= LOAD;
              end
            end else begin
              phase <= phase + 8'd1;
            end
          end
          FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
